// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// a width helper for the settle countdown.
package tt_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle countdown: load sets the count, then it decrements to zero and
// holds; expire is high whenever the count sits at zero.
module tt_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector, holds each for
// SETTLE cycles, and compares the DUT response against a golden table.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned SETTLE      = 10,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err_idx
);

  localparam int unsigned VW = N_IN;
  localparam int unsigned EW = N_IN + 1;
  localparam int unsigned CW = clog2_min1(SETTLE);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [VW-1:0] VEC_LAST  = {VW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [EW-1:0] err_q, err_d;
  logic [VW-1:0] fe_q, fe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          load_c;
  logic          expire_c;
  logic          mismatch_c;

  tt_settle_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .value  (SETTLE_LD),
    .expire (expire_c)
  );

  assign mismatch_c = (dut_out != expected[vec_q]);

  // Next-state: start from IDLE/DONE, sample/advance in RUN, abort wins over sample.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fe_d    = fe_q;
    busy_d  = busy_q;
    done_d  = done_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          vec_d   = '0;
          err_d   = '0;
          fe_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          load_c  = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (expire_c) begin
          if (mismatch_c) begin
            err_d = err_q + EW'(1);
            if (err_q == '0) fe_d = vec_q;
          end
          if ((vec_q == VEC_LAST) || (STOP_ON_ERR && mismatch_c)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d  = vec_q + VW'(1);
            load_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fe_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec           = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fe_q;

endmodule

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper: a 4-input AND gate with injectable output
// faults, one sweeper free-running and one stopping at the first error.
module tb_tt_sweeper;

  logic        clk;
  logic        rst;
  logic        start0, start1, abort;
  logic [15:0] expected;
  logic [15:0] fault0, fault1;

  logic        dut_out0, dut_out1;
  logic [3:0]  vec0, vec1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [4:0]  err0, err1;
  logic [3:0]  fe0, fe1;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  tt_sweeper #(.N_IN(4), .SETTLE(10), .STOP_ON_ERR(1'b0)) u_dut0 (
    .clk (clk), .rst (rst), .start (start0), .abort (abort),
    .expected (expected), .dut_out (dut_out0), .vec (vec0),
    .busy (busy0), .done (done0), .pass (pass0),
    .err_count (err0), .first_err_idx (fe0)
  );

  tt_sweeper #(.N_IN(4), .SETTLE(10), .STOP_ON_ERR(1'b1)) u_dut1 (
    .clk (clk), .rst (rst), .start (start1), .abort (abort),
    .expected (expected), .dut_out (dut_out1), .vec (vec1),
    .busy (busy1), .done (done1), .pass (pass1),
    .err_count (err1), .first_err_idx (fe1)
  );

  // Device under sweep: 4-input AND, MSB of vec is input A.
  assign dut_out0 = (&vec0) ^ fault0[vec0];
  assign dut_out1 = (&vec1) ^ fault1[vec1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the start-sampling edge until done rises (bounded).
  task automatic wait_done(input bit inst, output int cnt);
    cnt = 0;
    while ((inst ? done1 : done0) == 1'b0 && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    expected = 16'h8000; fault0 = '0; fault1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec",  32'(vec0),  0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_pass", 32'(pass0), 0);
    check("rst_err",  32'(err0),  0);
    rst = 1'b0;
    tick();

    // Clean full sweep
    pulse_start0();
    check("t1_vec0",  32'(vec0),  0);
    check("t1_busy",  32'(busy0), 1);
    wait_done(1'b0, n);
    check("t1_lat",   32'(n),     160);
    check("t1_pass",  32'(pass0), 1);
    check("t1_err",   32'(err0),  0);
    check("t1_vec",   32'(vec0),  15);
    check("t1_busy0", 32'(busy0), 0);

    // Faults on vectors 5 and 9, restarted from DONE
    fault0 = 16'h0220;
    pulse_start0();
    check("t2_vec0",  32'(vec0),  0);
    check("t2_done0", 32'(done0), 0);
    wait_done(1'b0, n);
    check("t2_lat",   32'(n),     160);
    check("t2_err",   32'(err0),  2);
    check("t2_fe",    32'(fe0),   5);
    check("t2_pass",  32'(pass0), 0);

    // Stop-on-error instance, fault on vector 3
    fault1 = 16'h0008;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done(1'b1, n);
    check("t3_lat",   32'(n),     40);
    check("t3_vec",   32'(vec1),  3);
    check("t3_err",   32'(err1),  1);
    check("t3_fe",    32'(fe1),   3);
    check("t3_pass",  32'(pass1), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_ign", 32'(done1), 1);

    // Second start mid-sweep is ignored
    fault0 = '0;
    pulse_start0();
    repeat (19) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t4_vec20", 32'(vec0),  2);
    wait_done(1'b0, n);
    check("t4_lat",   32'(20 + n), 160);
    check("t4_pass",  32'(pass0), 1);

    // Abort coinciding with the sample of vector 4
    pulse_start0();
    repeat (49) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy",  32'(busy0), 0);
    check("t5_done",  32'(done0), 0);
    check("t5_vec",   32'(vec0),  4);
    repeat (15) tick();
    check("t5_hold",  32'(vec0),  4);
    pulse_start0();
    check("t5_rvec",  32'(vec0),  0);
    check("t5_rbusy", 32'(busy0), 1);

    // Asynchronous reset mid-sweep, fault on vector 2 to make err nonzero
    fault0 = 16'h0004;
    pulse_start0();
    repeat (70) tick();
    check("t6_vec70", 32'(vec0),  7);
    check("t6_err70", 32'(err0),  1);
    #2 rst = 1'b1;
    #1;
    check("t6_rvec",  32'(vec0),  0);
    check("t6_rbusy", 32'(busy0), 0);
    check("t6_rerr",  32'(err0),  0);
    check("t6_rfe",   32'(fe0),   0);
    check("t6_rdone", 32'(done0), 0);
    check("t6_rdone1", 32'(done1), 0);
    #2 rst = 1'b0;
    tick();
    fault0 = '0;
    pulse_start0();
    check("t6_svec",  32'(vec0),  0);
    wait_done(1'b0, n);
    check("t6_lat",   32'(n),     160);
    check("t6_pass",  32'(pass0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_sweeper.md
TT_SWEEPER -- requirements
Module: tt_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of DUT inputs; sweep covers 2^N_IN vectors.
REQ-002 SHALL have parameter SETTLE, default 10: clock cycles each vector is held before sampling; legal range 1..255.
REQ-003 SHALL have parameter STOP_ON_ERR, default 0: 1 = end the sweep at the first mismatch.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a sweep.
REQ-007 SHALL have port abort  input  1  one-cycle pulse that cancels a running sweep.
REQ-008 SHALL have port expected  input  2^N_IN  golden truth table; bit i is the expected output for vector i.
REQ-009 SHALL have port dut_out  input  1  DUT response, combinational from vec.
REQ-010 SHALL have port vec  output  N_IN  registered stimulus; MSB maps to the DUT's first input (A).
REQ-011 SHALL have port busy  output  1  high while a sweep is running.
REQ-012 SHALL have port done  output  1  level, high after sweep completion until the next start or reset.
REQ-013 SHALL have port pass  output  1  done AND err_count == 0.
REQ-014 SHALL have port err_count  output  N_IN+1  number of mismatching vectors.
REQ-015 SHALL have port first_err_idx  output  N_IN  index of the first mismatch; valid only when err_count != 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, on start in IDLE or DONE: clear vec, err_count, first_err_idx and done; load the settle counter with SETTLE-1; enter RUN.
REQ-018 SHALL, for a start sampled at edge k, present vec=0 and busy=1 from edge k+1.
REQ-019 SHALL, in RUN, hold vec for exactly SETTLE cycles and compare dut_out with expected[vec] on the last of those cycles.
REQ-020 SHALL, on a mismatch, increment err_count and capture first_err_idx only if err_count was 0 before the increment.
REQ-021 SHALL, on the sample cycle with vec < 2^N_IN-1 and no stop condition, increment vec and reload the settle counter at the same edge; there SHALL be no gap cycles.
REQ-022 SHALL, on the sample cycle with vec == 2^N_IN-1, or with a mismatch while STOP_ON_ERR=1, enter DONE: busy=0, done=1, vec held at its last value.
REQ-023 SHALL complete a full sweep with done rising at edge k + 2^N_IN*SETTLE.
REQ-024 SHALL ignore start while in RUN.
REQ-025 SHALL, on abort in RUN, return to IDLE with busy=0 and done=0, keeping vec and err_count frozen; abort SHALL be ignored outside RUN.
REQ-026 SHALL give abort priority when abort and the final sample coincide (no DONE entry).
REQ-027 SHALL never saturate or wrap err_count, whose width holds 2^N_IN.

Reset
REQ-028 SHALL, on rst high, immediately and asynchronously force state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, settle counter=0.
REQ-029 SHALL, on reset asserted mid-sweep, discard all progress; the next start begins again from vector 0.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/DONE) and a clog2 helper for the settle-counter width in shared package tt_pkg.
REQ-031 SHALL implement the settle countdown as sub-module tt_settle_timer (inputs load and value; output expire).

Verification
REQ-032 SHALL cover: N_IN=4, SETTLE=10, DUT = 4-input AND, expected=16'h8000, start -> done exactly 160 cycles later, pass=1, err_count=0, vec=15.
REQ-033 SHALL cover: same setup, DUT output forced wrong on vectors 5 and 9 -> err_count=2, first_err_idx=5, pass=0.
REQ-034 SHALL cover: STOP_ON_ERR=1, DUT wrong on vector 3 -> done 40 cycles after start, vec=3, err_count=1.
REQ-035 SHALL cover: start pulsed again 20 cycles into a sweep -> no restart; done still arrives at cycle 160.
REQ-036 SHALL cover: abort at cycle 50 -> busy=0, done=0, vec=4 held; a following start gives vec=0 on the next cycle.
REQ-037 SHALL cover: rst asserted asynchronously between clock edges at cycle 70 -> all outputs 0 before the next edge; a fresh sweep then passes.
